// File: rtl/spi_byte_tx_if.sv
// Byte-level handshake and SPI pin bundle for spi_byte_tx.
// The master side is the upstream/bench; the slave side is the transmitter.
interface spi_byte_tx_if;
   logic       write;
   logic [7:0] byte_send;
   logic       busy;
   logic       sclk;
   logic       mosi;
   logic       cs_n;
   logic       miso;
   logic [7:0] byte_recv;
   logic       recv_valid;

   modport master (
      output write, byte_send, miso,
      input  busy, sclk, mosi, cs_n, byte_recv, recv_valid
   );

   modport slave (
      input  write, byte_send, miso,
      output busy, sclk, mosi, cs_n, byte_recv, recv_valid
   );
endinterface

// File: rtl/spi_byte_tx.sv
// SPI mode-0 master byte transmitter, MSB first, with cs_n held low across back-to-back bytes.
// Optional receive capture of miso is built when SPI_RX_CAPTURE_EN is defined.
module spi_byte_tx #(
   parameter int CLK_DIV = 4,
   parameter int CS_HOLD = 8
) (
   input  logic          clk,
   input  logic          rst,
   spi_byte_tx_if.slave  bus
);

   localparam int CNT_MAX = (CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             sclk_q, sclk_d;
   logic             mosi_q, mosi_d;
   logic             cs_n_q, cs_n_d;
   logic             start_s;
   logic             cnt_end_s;
   logic             hold_end_s;

   // busy is low only in IDLE and HOLD, so it alone qualifies a new request
   assign start_s    = bus.write && !busy_q;
   assign cnt_end_s  = (cnt_q == CNT_W'(CLK_DIV - 1));
   assign hold_end_s = (cnt_q == CNT_W'(CS_HOLD - 1));

   // Next-state and next-output logic for the transmit sequencer
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;
      if (start_s) begin
         state_d = ST_SETUP;
         cnt_d   = '0;
         bit_d   = 3'd0;
         tx_d    = bus.byte_send;
         busy_d  = 1'b1;
         cs_n_d  = 1'b0;
         mosi_d  = bus.byte_send[7];
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
            end
            ST_SETUP: begin
               if (cnt_end_s) begin
                  cnt_d   = '0;
                  sclk_d  = 1'b1;
                  state_d = ST_SHIFT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_SHIFT: begin
               if (!cnt_end_s) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end else if (sclk_q) begin
                  // falling edge: present the next bit, zero-fill behind it
                  cnt_d  = '0;
                  sclk_d = 1'b0;
                  tx_d   = {tx_q[6:0], 1'b0};
                  mosi_d = tx_q[6];
               end else if (bit_q == 3'd7) begin
                  cnt_d  = '0;
                  busy_d = 1'b0;
                  mosi_d = 1'b0;
                  if (CS_HOLD == 0) begin
                     cs_n_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end else begin
                  cnt_d  = '0;
                  bit_d  = bit_q + 3'd1;
                  sclk_d = 1'b1;
               end
            end
            ST_HOLD: begin
               if (hold_end_s) begin
                  cnt_d   = '0;
                  cs_n_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
               sclk_d  = 1'b0;
               mosi_d  = 1'b0;
               cs_n_d  = 1'b1;
            end
         endcase
      end
   end

   // Sequencer state and registered SPI outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         tx_q    <= 8'h00;
         busy_q  <= 1'b0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.sclk = sclk_q;
   assign bus.mosi = mosi_q;
   assign bus.cs_n = cs_n_q;

`ifdef SPI_RX_CAPTURE_EN
   logic [7:0] rx_q, rx_d;
   logic [7:0] byte_recv_q, byte_recv_d;
   logic       recv_valid_q, recv_valid_d;
   logic       fall_s, done_s;

   assign fall_s = (state_q == ST_SHIFT) && cnt_end_s && sclk_q && !start_s;
   assign done_s = (state_q == ST_SHIFT) && cnt_end_s && !sclk_q && (bit_q == 3'd7) && !start_s;

   // Receive shifter: sample miso on sclk fall, publish on busy fall
   always_comb begin
      rx_d         = rx_q;
      byte_recv_d  = byte_recv_q;
      recv_valid_d = 1'b0;
      if (fall_s) begin
         rx_d = {rx_q[6:0], bus.miso};
      end else begin
         rx_d = rx_q;
      end
      if (done_s) begin
         byte_recv_d  = rx_q;
         recv_valid_d = 1'b1;
      end else begin
         recv_valid_d = 1'b0;
      end
   end

   // Receive registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_q         <= 8'h00;
         byte_recv_q  <= 8'h00;
         recv_valid_q <= 1'b0;
      end else begin
         rx_q         <= rx_d;
         byte_recv_q  <= byte_recv_d;
         recv_valid_q <= recv_valid_d;
      end
   end

   assign bus.byte_recv  = byte_recv_q;
   assign bus.recv_valid = recv_valid_q;
`else
   assign bus.byte_recv  = 8'h00;
   assign bus.recv_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_tx.sv
// Self-checking bench for spi_byte_tx: two instances (CLK_DIV=4/CS_HOLD=8 and CLK_DIV=1/CS_HOLD=0)
// compared cycle by cycle against waveforms computed from the byte timing formulas.
module tb_spi_byte_tx;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_byte_tx_if if_a ();
   spi_byte_tx_if if_b ();

   spi_byte_tx #(.CLK_DIV(4), .CS_HOLD(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
   spi_byte_tx #(.CLK_DIV(1), .CS_HOLD(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

`ifdef SPI_RX_CAPTURE_EN
   localparam bit RX_EN = 1'b1;
`else
   localparam bit RX_EN = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Model SPI slaves: present bit idx of their byte, advance on each sclk fall
   logic [7:0] slave_a = 8'h00, slave_b = 8'h00;
   logic [2:0] idx_a, idx_b;
   always @(negedge if_a.sclk or posedge rst) begin
      if (rst) idx_a <= 3'd7;
      else     idx_a <= idx_a - 3'd1;
   end
   always @(negedge if_b.sclk or posedge rst) begin
      if (rst) idx_b <= 3'd7;
      else     idx_b <= idx_b - 3'd1;
   end
   assign if_a.miso = slave_a[idx_a];
   assign if_b.miso = slave_b[idx_b];

   // mosi as seen by the slave on every rising sclk
   logic q_a[$];
   logic q_b[$];
   always @(posedge if_a.sclk) q_a.push_back(if_a.mosi);
   always @(posedge if_b.sclk) q_b.push_back(if_b.mosi);

   function automatic logic [12:0] obs(input bit sel);
      if (sel) return {if_b.busy, if_b.sclk, if_b.mosi, if_b.cs_n, if_b.recv_valid, if_b.byte_recv};
      else     return {if_a.busy, if_a.sclk, if_a.mosi, if_a.cs_n, if_a.recv_valid, if_a.byte_recv};
   endfunction

   task automatic drive_write(input bit sel, input logic v, input logic [7:0] b);
      if (sel) begin
         if_b.write = v; if_b.byte_send = b;
      end else begin
         if_a.write = v; if_a.byte_send = b;
      end
   endtask

   // Send one byte and check every cycle from E0 to the end of busy (or cs_n rise if tail)
   task automatic send(input bit sel, input logic [7:0] b, input logic [7:0] sb,
                       input int gap, input int extra_t, input bit tail);
      int d, h, last, k;
      logic [12:0] o;
      bit e_busy, e_sclk, e_cs;
      d = sel ? 1 : 4;
      h = sel ? 0 : 8;
      repeat (gap) @(negedge clk);
      if (sel) slave_b = sb; else slave_a = sb;
      drive_write(sel, 1'b1, b);
      @(negedge clk);
      last = tail ? 17*d + h : 17*d;
      for (int t = 0; t <= last; t++) begin
         o      = obs(sel);
         e_busy = (t < 17*d);
         e_sclk = (t >= d) && (t < 16*d) && ((((t - d) / d) % 2) == 0);
         e_cs   = (t >= 17*d + h);
         check_eq($sformatf("busy u%0d b%02h t%0d", sel, b, t), o[12], e_busy);
         check_eq($sformatf("sclk u%0d b%02h t%0d", sel, b, t), o[11], e_sclk);
         check_eq($sformatf("cs_n u%0d b%02h t%0d", sel, b, t), o[9], e_cs);
         if (e_sclk) begin
            k = (t - d) / (2*d);
            check_eq($sformatf("mosi u%0d b%02h t%0d", sel, b, t), o[10], b[7-k]);
         end else if (t >= 17*d) begin
            check_eq($sformatf("mosi_idle u%0d t%0d", sel, t), o[10], 1'b0);
         end
         check_eq($sformatf("recv_valid u%0d t%0d", sel, t), o[8], RX_EN && (t == 17*d));
         if (t == 17*d)
            check_eq($sformatf("byte_recv u%0d", sel), o[7:0], RX_EN ? sb : 8'h00);
         drive_write(sel, (t == extra_t - 1), 8'($urandom));
         if (t < last) @(negedge clk);
      end
   endtask

   task automatic check_q(input bit sel, input int n, input logic [31:0] exp_val, input string tag);
      int sz;
      logic [31:0] v;
      v  = 32'h0;
      sz = sel ? q_b.size() : q_a.size();
      check_eq({tag, "_edges"}, sz, n);
      if (n <= 32) begin
         for (int i = 0; i < sz && i < 32; i++)
            v = {v[30:0], (sel ? q_b[i] : q_a[i])};
         check_eq({tag, "_bits"}, v, exp_val);
      end
      q_a.delete();
      q_b.delete();
   endtask

   initial begin
      logic [12:0] o;
      int nbytes;
      bit tail, prev_tail;
      int gap;
      rst = 1'b1;
      drive_write(1'b0, 1'b0, 8'h00);
      drive_write(1'b1, 1'b0, 8'h00);
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         o = obs(s[0]);
         check_eq($sformatf("rst_busy u%0d", s), o[12], 1'b0);
         check_eq($sformatf("rst_sclk u%0d", s), o[11], 1'b0);
         check_eq($sformatf("rst_mosi u%0d", s), o[10], 1'b0);
         check_eq($sformatf("rst_cs_n u%0d", s), o[9], 1'b1);
         check_eq($sformatf("rst_rv u%0d", s), o[8], 1'b0);
         check_eq($sformatf("rst_br u%0d", s), o[7:0], 8'h00);
      end
      rst = 1'b0;
      q_a.delete(); q_b.delete();
      repeat (2) @(negedge clk);

      send(1'b0, 8'hA5, 8'h5A, 0, -1, 1'b1);
      check_q(1'b0, 8, 32'h0000_00A5, "single_a5");

      send(1'b0, 8'hDE, 8'($urandom), 2, -1, 1'b0);
      send(1'b0, 8'hAD, 8'($urandom), 0, -1, 1'b0);
      send(1'b0, 8'hBE, 8'($urandom), 0, -1, 1'b0);
      send(1'b0, 8'hEF, 8'($urandom), 0, -1, 1'b1);
      check_q(1'b0, 32, 32'hDEAD_BEEF, "frame");

      send(1'b0, 8'h3C, 8'hC3, 3, 10, 1'b1);
      check_q(1'b0, 8, 32'h0000_003C, "ignored_wr");

      // write landing on the HOLD terminal cycle must keep cs_n low
      send(1'b0, 8'h96, 8'h11, 1, -1, 1'b0);
      send(1'b0, 8'h69, 8'h22, 7, -1, 1'b1);
      check_q(1'b0, 16, 32'h0000_9669, "hold_term");

      slave_a = 8'h33;
      drive_write(1'b0, 1'b1, 8'hFF);
      @(negedge clk);
      drive_write(1'b0, 1'b0, 8'h00);
      repeat (29) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 o = obs(1'b0);
      check_eq("abort_busy", o[12], 1'b0);
      check_eq("abort_sclk", o[11], 1'b0);
      check_eq("abort_cs_n", o[9], 1'b1);
      check_eq("abort_rv", o[8], 1'b0);
      check_eq("abort_br", o[7:0], 8'h00);
      check_q(1'b0, 4, 32'h0000_000F, "abort_ff");
      @(negedge clk);
      rst = 1'b0;
      send(1'b0, 8'h81, 8'h7E, 1, -1, 1'b1);
      check_q(1'b0, 8, 32'h0000_0081, "after_rst");

      send(1'b1, 8'h01, 8'h5A, 2, -1, 1'b1);
      check_q(1'b1, 8, 32'h0000_0001, "div1_01");

      for (int s = 0; s < 2; s++) begin
         nbytes    = 0;
         prev_tail = 1'b1;
         for (int i = 0; i < 6; i++) begin
            tail = (i == 5) || ($urandom_range(0, 1) == 1);
            if (prev_tail) gap = $urandom_range(1, 3);
            else if (s == 0) gap = $urandom_range(0, 7);
            else gap = 0;
            send(s[0], 8'($urandom), 8'($urandom), gap, -1, tail);
            prev_tail = tail;
            nbytes++;
         end
         check_q(s[0], 8*nbytes, 32'h0, $sformatf("rand_u%0d", s));
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
